hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_pkg.sv | 13 +
 rtl/hazard_controller_forward_select.sv | 21 ++
 rtl/hazard_controller.sv | 129 ++++++++++++
 tb/tb_hazard_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared pipeline constants: forwarding mux encodings and hazard FSM states.
package hazard_controller_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hc_state_e;

endpackage

// File: rtl/hazard_controller_forward_select.sv
// Forwarding source select for one execute-stage operand; the MEM stage has priority over WB.
module forward_select
  import hazard_controller_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] write_reg_m_i,
  input  logic       reg_write_w_i,
  input  logic [4:0] write_reg_w_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (write_reg_m_i == rs_i) && (rs_i != 5'd0))
      fwd_o = FWD_MEM;
    else if (reg_write_w_i && (write_reg_w_i == rs_i) && (rs_i != 5'd0))
      fwd_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard unit: operand forwarding, load-use/branch stalls, data-memory wait FSM
// with a sticky timeout flag and a stall-cycle performance counter.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        BranchD,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  input  logic        PerfClear,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles
);

  // One spare bit so the saturation point always lies past TIMEOUT_CYCLES.
  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [WCNT_W-1:0] WCNT_TO = WCNT_W'(TIMEOUT_CYCLES);

  hc_state_e         state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q;
  logic [15:0]       stall_cnt_q;
  logic              mem_stall, load_use, br_hz;

  forward_select u_fwd_a (
    .rs_i(RsE), .reg_write_m_i(RegWriteM), .write_reg_m_i(WriteRegM),
    .reg_write_w_i(RegWriteW), .write_reg_w_i(WriteRegW), .fwd_o(ForwardAE)
  );

  forward_select u_fwd_b (
    .rs_i(RtE), .reg_write_m_i(RegWriteM), .write_reg_m_i(WriteRegM),
    .reg_write_w_i(RegWriteW), .write_reg_w_i(WriteRegW), .fwd_o(ForwardBE)
  );

  assign load_use = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
  assign br_hz    = BranchD &&
                    ((RegWriteE && (WriteRegE != 5'd0) && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                     (MemtoRegM && (WriteRegM != 5'd0) && ((WriteRegM == RsD) || (WriteRegM == RtD))));
  assign mem_stall = (state_q == MEM_WAIT) || (MemReqM && !MemReadyM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (MemReqM && !MemReadyM) state_d = MEM_WAIT;
      MEM_WAIT: if (MemReadyM)             state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Memory wait dominates; a hazard stalls fetch/decode and bubbles execute.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (!reset_n) begin
      StallF = 1'b0;
    end else if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (load_use || br_hz) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (BranchD) begin
      FlushD = 1'b1;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == RUN && state_d == MEM_WAIT)
      wait_cnt_d = '0;
    else if (state_q == MEM_WAIT && wait_cnt_q != '1)
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (state_q == MEM_WAIT && wait_cnt_q >= WCNT_TO)
        timeout_q <= 1'b1;
      if (PerfClear)
        stall_cnt_q <= '0;
      else if (StallF && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: driver queues expected outputs, a negedge monitor checks them.
module tb_hazard_controller;

  localparam int K_STALL = 0, K_FLUSH = 1, K_FA = 2, K_FB = 3, K_SC = 4, K_TO = 5;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic        BranchD, MemReqM, MemReadyM, PerfClear;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] stall_cycles;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  hazard_controller #(.TIMEOUT_CYCLES(255)) dut (
    .clock(clock), .reset_n(reset_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .PerfClear(PerfClear),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input int kind, input logic [15:0] v, input string nm);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic idle_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
    MemReqM = 0; MemReadyM = 0; PerfClear = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle_inputs();
  endtask

  // Monitor: drains every expectation queued before this falling edge.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clock);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        case (e.kind)
          K_STALL: act = {12'd0, StallF, StallD, StallE, StallM};
          K_FLUSH: act = {14'd0, FlushD, FlushE};
          K_FA:    act = {14'd0, ForwardAE};
          K_FB:    act = {14'd0, ForwardBE};
          K_SC:    act = stall_cycles;
          default: act = {15'd0, mem_timeout};
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    #1;
    chk(K_STALL, 16'h0, "rst_stall");
    chk(K_FLUSH, 16'h0, "rst_flush");
    chk(K_SC,    16'h0, "rst_sc");
    chk(K_TO,    16'h0, "rst_to");
    step(); reset_n = 1'b1;

    // Forwarding
    step(); RegWriteM = 1; WriteRegM = 5; RsE = 5; RegWriteW = 1; WriteRegW = 5;
    chk(K_FA, 16'h2, "fwd_mem_prio"); chk(K_FB, 16'h0, "fwd_b_rf");
    chk(K_STALL, 16'h0, "fwd_nostall");
    step(); RegWriteM = 1; WriteRegM = 5; RsE = 0; RegWriteW = 1; WriteRegW = 5;
    chk(K_FA, 16'h0, "fwd_r0");
    step(); RegWriteW = 1; WriteRegW = 5; RsE = 5; RtE = 5;
    chk(K_FA, 16'h1, "fwd_a_wb"); chk(K_FB, 16'h1, "fwd_b_wb");
    step(); RegWriteM = 1; WriteRegM = 7; RegWriteW = 1; WriteRegW = 5; RsE = 5; RtE = 7;
    chk(K_FA, 16'h1, "fwd_a_wb2"); chk(K_FB, 16'h2, "fwd_b_mem");
    step(); WriteRegM = 5; WriteRegW = 5; RsE = 5;
    chk(K_FA, 16'h0, "fwd_nowrite");

    // Load-use
    step(); MemtoRegE = 1; RtE = 3; RsD = 3;
    chk(K_STALL, 16'hC, "lu_rs_stall"); chk(K_FLUSH, 16'h1, "lu_rs_flush");
    step();
    chk(K_STALL, 16'h0, "lu_after_stall"); chk(K_FLUSH, 16'h0, "lu_after_flush");
    chk(K_SC, 16'd1, "lu_sc1");
    step(); MemtoRegE = 1; RtE = 4; RtD = 4;
    chk(K_STALL, 16'hC, "lu_rt_stall"); chk(K_FLUSH, 16'h1, "lu_rt_flush");
    step(); MemtoRegE = 1;
    chk(K_STALL, 16'h0, "lu_r0_nostall"); chk(K_SC, 16'd2, "lu_sc2");

    // Branches
    step(); BranchD = 1; RsD = 1; RtD = 2;
    chk(K_FLUSH, 16'h2, "br_flushd"); chk(K_STALL, 16'h0, "br_nostall");
    step();
    chk(K_FLUSH, 16'h0, "br_flushd_off");
    step(); BranchD = 1; RegWriteE = 1; WriteRegE = 2; RtD = 2;
    chk(K_STALL, 16'hC, "brhz_e_stall"); chk(K_FLUSH, 16'h1, "brhz_e_flush");
    step();
    chk(K_SC, 16'd3, "brhz_sc3");
    step(); BranchD = 1; MemtoRegM = 1; WriteRegM = 1; RsD = 1;
    chk(K_STALL, 16'hC, "brhz_m_stall"); chk(K_FLUSH, 16'h1, "brhz_m_flush");
    step(); PerfClear = 1;
    chk(K_SC, 16'd4, "sc4");
    step(); PerfClear = 1; MemtoRegE = 1; RtE = 3; RsD = 3;
    chk(K_SC, 16'd0, "sc_clear"); chk(K_STALL, 16'hC, "clr_lu_stall");
    step();
    chk(K_SC, 16'd0, "sc_clear_wins");

    // Memory wait: 4 not-ready cycles then ready
    for (int i = 0; i < 5; i++) begin
      step(); MemReqM = 1; MemReadyM = (i == 4); BranchD = 1; RsD = 1;
      if (i == 2) begin MemtoRegE = 1; RtE = 1; end
      chk(K_STALL, 16'hF, "mw_stall"); chk(K_FLUSH, 16'h0, "mw_noflush");
    end
    step();
    chk(K_STALL, 16'h0, "mw_back_run"); chk(K_SC, 16'd5, "mw_sc5");

    // Timeout
    step(); PerfClear = 1;
    step(); MemReqM = 1;
    chk(K_SC, 16'd0, "to_sc0"); chk(K_TO, 16'h0, "to_init");
    for (int i = 1; i < 300; i++) begin
      step(); MemReqM = 1;
      if (i == 250) chk(K_TO, 16'h0, "to_early");
      if (i == 260) chk(K_TO, 16'h1, "to_set");
    end
    step(); MemReqM = 1; MemReadyM = 1;
    chk(K_STALL, 16'hF, "to_last_stall");
    step();
    chk(K_STALL, 16'h0, "to_run"); chk(K_TO, 16'h1, "to_sticky");
    chk(K_SC, 16'd301, "to_sc301");
    step();
    chk(K_TO, 16'h1, "to_sticky2");

    // Asynchronous reset in the middle of a wait
    step(); MemReqM = 1;
    step(); MemReqM = 1;
    step(); MemReqM = 1; RegWriteM = 1; WriteRegM = 9; RsE = 9;
    #2 reset_n = 1'b0;
    chk(K_STALL, 16'h0, "arst_stall"); chk(K_FLUSH, 16'h0, "arst_flush");
    chk(K_SC, 16'h0, "arst_sc"); chk(K_TO, 16'h0, "arst_to");
    chk(K_FA, 16'h2, "arst_fwd");
    step(); reset_n = 1'b1;
    chk(K_STALL, 16'h0, "post_rst_run"); chk(K_SC, 16'h0, "post_rst_sc");
    step(); MemReqM = 1; MemReadyM = 1;
    chk(K_STALL, 16'h0, "post_rst_ready");

    repeat (2) @(posedge clock);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
